// File: rtl/pe_conv_top.sv
// Mixed-width conversion tile: lockstep broadcast of in0/in1 into a
// sign-extending PE (out) and a zero-extending PE (out_u), each with a
// one-deep registered output slot.
module pe_conv_top #(
    parameter int unsigned IN0_W = 16,
    parameter int unsigned IN1_W = 32,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [IN0_W-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [IN1_W-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_u_valid,
    input  logic             out_u_ready,
    output logic [OUT_W-1:0] out_u_data,
    input  logic [1:0]       bcast_in0_cfg_route_table,
    input  logic [1:0]       bcast_in1_cfg_route_table,
    output logic             error_valid,
    output logic [15:0]      error_code
);

    localparam int unsigned NPE   = 2;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned EXT_W = IN1_W - IN0_W;

    localparam logic [ERR_W-1:0] ERR_IN0 = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_IN1 = ERR_W'(2);

    logic [NPE-1:0]   route0_c;
    logic [NPE-1:0]   route1_c;
    logic [NPE-1:0]   dest_c;
    logic [NPE-1:0]   both_c;
    logic [NPE-1:0]   accept_c;
    logic [NPE-1:0]   out_rdy_c;
    logic             join_ok_c;
    logic             fire_c;
    logic [IN1_W-1:0] ext_s_c;
    logic [IN1_W-1:0] ext_u_c;
    logic [OUT_W-1:0] res_c [NPE];

    logic [NPE-1:0]   valid_q;
    logic [NPE-1:0]   valid_d;
    logic [OUT_W-1:0] data_q [NPE];
    logic [OUT_W-1:0] data_d [NPE];

    logic             err_valid_q;
    logic             err_valid_d;
    logic [ERR_W-1:0] err_code_q;
    logic [ERR_W-1:0] err_code_d;

    assign route0_c  = bcast_in0_cfg_route_table;
    assign route1_c  = bcast_in1_cfg_route_table;
    assign out_rdy_c = {out_u_ready, out_ready};

    // Slot acceptance and lockstep join: every PE reached by either input
    // must hold both operands and have a free (or draining) slot.
    always_comb begin
        dest_c    = route0_c | route1_c;
        both_c    = route0_c & route1_c;
        accept_c  = ~valid_q | out_rdy_c;
        join_ok_c = &(~dest_c | (both_c & accept_c));
    end

    // Readiness of one input depends only on the partner's valid, never its own;
    // an unrouted input (table 00) is held not-ready.
    assign in0_ready = (route0_c != '0) && (route1_c != '0) && in1_valid && join_ok_c;
    assign in1_ready = (route0_c != '0) && (route1_c != '0) && in0_valid && join_ok_c;
    assign fire_c    = in0_valid && in0_ready;

    // Extension and modular add; only the low OUT_W bits of the sum are kept.
    always_comb begin
        ext_s_c  = {{EXT_W{in0_data[IN0_W-1]}}, in0_data};
        ext_u_c  = IN1_W'(in0_data);
        res_c[0] = OUT_W'(ext_s_c + in1_data);
        res_c[1] = OUT_W'(ext_u_c + in1_data);
    end

    // Output slot next state: refill on fire, otherwise drain on handshake.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < int'(NPE); k++) begin
            if (fire_c && both_c[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = res_c[k];
            end else if (out_rdy_c[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < int'(NPE); k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Sticky config error capture; in0 wins a same-cycle tie, first code held.
    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        if (!err_valid_q) begin
            if (in0_valid && (route0_c == '0)) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_IN0;
            end else if (in1_valid && (route1_c == '0)) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_IN1;
            end
        end
    end

    // Error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid   = valid_q[0];
    assign out_data    = data_q[0];
    assign out_u_valid = valid_q[1];
    assign out_u_data  = data_q[1];
    assign error_valid = err_valid_q;
    assign error_code  = err_code_q;

endmodule

// File: tb/tb_pe_conv_top.sv
// Scoreboard bench for pe_conv_top: expected results are queued when an
// input pair handshakes and compared when each output handshakes.
module tb_pe_conv_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in0_ready;
    logic [15:0] in0_data;
    logic        in1_valid, in1_ready;
    logic [31:0] in1_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_u_valid, out_u_ready;
    logic [15:0] out_u_data;
    logic [1:0]  route0, route1;
    logic        error_valid;
    logic [15:0] error_code;

    int checks   = 0;
    int failures = 0;
    bit rand_rdy = 1'b0;

    logic [15:0] q_s[$];
    logic [15:0] q_u[$];

    always #5 clk = ~clk;

    pe_conv_top dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .in0_valid                 (in0_valid),
        .in0_ready                 (in0_ready),
        .in0_data                  (in0_data),
        .in1_valid                 (in1_valid),
        .in1_ready                 (in1_ready),
        .in1_data                  (in1_data),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_data                  (out_data),
        .out_u_valid               (out_u_valid),
        .out_u_ready               (out_u_ready),
        .out_u_data                (out_u_data),
        .bcast_in0_cfg_route_table (route0),
        .bcast_in1_cfg_route_table (route1),
        .error_valid               (error_valid),
        .error_code                (error_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_s(input logic [15:0] a, input logic [31:0] b);
        logic [31:0] e;
        e = {{16{a[15]}}, a};
        return 16'(e + b);
    endfunction

    function automatic logic [15:0] model_u(input logic [15:0] a, input logic [31:0] b);
        logic [31:0] e;
        e = {16'h0000, a};
        return 16'(e + b);
    endfunction

    // Scoreboard: pop on output handshake before pushing this cycle's new pair.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q_s.size() == 0) check("s_extra", 32'(1), 32'(0));
                else check("s_data", 32'(out_data), 32'(q_s.pop_front()));
            end
            if (out_u_valid && out_u_ready) begin
                if (q_u.size() == 0) check("u_extra", 32'(1), 32'(0));
                else check("u_data", 32'(out_u_data), 32'(q_u.pop_front()));
            end
            if (in0_valid && in0_ready && in1_valid && in1_ready) begin
                if (route0[0] && route1[0]) q_s.push_back(model_s(in0_data, in1_data));
                if (route0[1] && route1[1]) q_u.push_back(model_u(in0_data, in1_data));
            end
        end
    end

    // Random output backpressure while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready   = 1'($urandom_range(0, 1));
            out_u_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one pair until it handshakes; returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [31:0] b);
        int n = 0;
        in0_data  = a;
        in1_data  = b;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in0_ready && in1_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 32'(1), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready   = 1'b1;
        out_u_ready = 1'b1;
        while ((q_s.size() != 0 || q_u.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_s_empty", 32'(q_s.size()), 32'(0));
        check("drain_u_empty", 32'(q_u.size()), 32'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        in0_valid   = 1'b0;
        in1_valid   = 1'b0;
        in0_data    = '0;
        in1_data    = '0;
        out_ready   = 1'b1;
        out_u_ready = 1'b1;
        route0      = 2'b11;
        route1      = 2'b11;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",   32'(out_valid),   32'(0));
        check("rst_out_u_valid", 32'(out_u_valid), 32'(0));
        check("rst_error_valid", 32'(error_valid), 32'(0));
        check("rst_error_code",  32'(error_code),  32'(0));
        check("rst_out_data",    32'(out_data),    32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single transaction, 1-cycle latency
        send(16'd3, 32'd5);
        check("t2_out_valid",   32'(out_valid),   32'(1));
        check("t2_out_data",    32'(out_data),    32'(8));
        check("t2_out_u_valid", 32'(out_u_valid), 32'(1));
        check("t2_out_u_data",  32'(out_u_data),  32'(8));

        // Back-to-back streaming, extension boundaries
        send(16'hFFFF, 32'h0000_0001);
        check("t3a_out",   32'(out_data),   32'h0000);
        check("t3a_out_u", 32'(out_u_data), 32'h0000);
        send(16'h7FFF, 32'h0001_0000);
        check("t3b_out",   32'(out_data),   32'h7FFF);
        check("t3b_out_u", 32'(out_u_data), 32'h7FFF);
        send(16'h8000, 32'h0000_0000);
        check("t3c_out",   32'(out_data),   32'h8000);
        check("t3c_out_u", 32'(out_u_data), 32'h8000);
        send(16'h8001, 32'h0000_0002);
        check("t3d_out",   32'(out_data),   32'h8003);
        check("t3d_out_u", 32'(out_u_data), 32'h8003);
        drain();

        // Backpressure: result pending, next pair offered, consumer stalled
        out_ready   = 1'b0;
        out_u_ready = 1'b0;
        send(16'h0010, 32'h0000_0020);
        in0_data  = 16'h0001;
        in1_data  = 32'h0000_0002;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in0_ready", 32'(in0_ready), 32'(0));
            check("bp_in1_ready", 32'(in1_ready), 32'(0));
            check("bp_out_hold",  32'(out_data),  32'h0030);
            check("bp_out_valid", 32'(out_valid), 32'(1));
        end
        @(posedge clk);
        #1;
        out_ready   = 1'b1;
        out_u_ready = 1'b1;
        send(16'h0001, 32'h0000_0002);
        check("bp_next_out", 32'(out_data), 32'h0003);
        drain();

        // Random streaming with independent random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(16'($urandom), $urandom);
        end
        drain();

        // Reset mid-operation discards pending results
        out_ready   = 1'b0;
        out_u_ready = 1'b0;
        send(16'h1234, 32'h0000_1111);
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid",   32'(out_valid),   32'(0));
        check("mid_rst_out_u_valid", 32'(out_u_valid), 32'(0));
        check("mid_rst_out_data",    32'(out_data),    32'(0));
        q_s.delete();
        q_u.delete();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        out_ready   = 1'b1;
        out_u_ready = 1'b1;

        // Config error: in0 route table cleared while in0 is valid
        route0    = 2'b00;
        in0_data  = 16'h0005;
        in1_data  = 32'h0000_0006;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        @(negedge clk);
        check("err_in0_ready",   32'(in0_ready),   32'(0));
        check("err_before_edge", 32'(error_valid), 32'(0));
        @(negedge clk);
        check("err_valid", 32'(error_valid), 32'(1));
        check("err_code",  32'(error_code),  32'h0001);
        check("err_in0_ready_held", 32'(in0_ready), 32'(0));
        route1 = 2'b00;
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(error_valid), 32'(1));
        check("err_first_code_held", 32'(error_code), 32'h0001);
        check("err_no_output", 32'(out_valid), 32'(0));
        in0_valid = 1'b0;
        in1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
